// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: CPU port, debug/boot-loader port and RAM side.
// slave  = arbiter view, master = requester/RAM-model view.
interface ram_arbiter_if;
    logic        cpu_req;
    logic        cpu_wr;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;

    logic        dbg_req;
    logic        dbg_wr;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_wr;
    logic [31:0] ram_dout;

    logic        busy;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  ram_dout,
        output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        output ram_addr, ram_din, ram_wr, busy
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output ram_dout,
        input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        input  ram_addr, ram_din, ram_wr, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter (CPU + debug) in front of a single-port synchronous RAM.
// One transaction at a time: IDLE -> ACC -> [RD] -> DONE -> IDLE.
// ARB_ROUND_ROBIN_EN: when defined, ties alternate via last_gnt; otherwise
// the CPU always wins a tie.
module ram_arbiter (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nx;

    // Latched transaction; lat_own: 0 = CPU, 1 = debug port.
    logic        lat_wr;
    logic        lat_own;
    logic [8:0]  lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] cpu_rdata_q;
    logic [31:0] dbg_rdata_q;

    logic        any_req;
    logic        gnt_dbg;

    assign any_req = bus.cpu_req | bus.dbg_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt;

    // Tie goes to whichever port was not granted last.
    always_comb gnt_dbg = bus.dbg_req & (~bus.cpu_req | ~last_gnt);

    // Remember the owner of each grant for the next tie.
    always_ff @(posedge clk) begin
        if (reset)
            last_gnt <= 1'b0;
        else if (state == IDLE && any_req)
            last_gnt <= gnt_dbg;
    end
`else
    // Fixed priority: debug only wins when the CPU is not asking.
    always_comb gnt_dbg = bus.dbg_req & ~bus.cpu_req;
`endif

    // State register; reset aborts anything in flight.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and per-state strobes; all outputs depend only on state.
    always_comb begin
        state_nx    = state;
        bus.ram_wr  = 1'b0;
        bus.cpu_ack = 1'b0;
        bus.dbg_ack = 1'b0;
        bus.busy    = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (any_req)
                    state_nx = ACC;
            end
            ACC: begin
                bus.ram_wr = lat_wr;
                state_nx   = lat_wr ? DONE : RD;
            end
            RD: begin
                state_nx = DONE;
            end
            DONE: begin
                bus.cpu_ack = ~lat_own;
                bus.dbg_ack = lat_own;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the winner's request; requests are only looked at in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_wr    <= 1'b0;
            lat_own   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && any_req) begin
            lat_own   <= gnt_dbg;
            lat_wr    <= gnt_dbg ? bus.dbg_wr    : bus.cpu_wr;
            lat_addr  <= gnt_dbg ? bus.dbg_addr  : bus.cpu_addr;
            lat_wdata <= gnt_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        end
    end

    // RAM output is registered, so read data is valid during RD.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else if (state == RD) begin
            if (lat_own)
                dbg_rdata_q <= bus.ram_dout;
            else
                cpu_rdata_q <= bus.ram_dout;
        end
    end

    assign bus.ram_addr  = lat_addr;
    assign bus.ram_din   = lat_wdata;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;

endmodule
